// File: rtl/dpseq_pkg.sv
// Shared types for the datapath sequencer: micro-op command layout,
// FSM state encoding and register-file constants.
package dpseq_pkg;

  localparam int unsigned ALU_W = 4;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CMD_W = ALU_W + 3 * REG_W + 2;  // 21 bits packed

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ALU_W-1:0] alu_op;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             skipz;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Writes to x0 are architecturally discarded, so never pulse regwrite for them.
  function automatic logic writes_reg(input cmd_t c);
    return c.we && (c.rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/dpseq_fifo.sv
// DEPTH-entry synchronous command FIFO with flush; level/full/empty derived
// from a single occupancy counter. Pointers wrap modulo DEPTH (power of two).
module dpseq_fifo
  import dpseq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = CMD_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Storage array: written on accepted push, no reset needed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  // Pointer and occupancy tracking; flush discards all entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;

endmodule

// File: rtl/datapath_sequencer.sv
// Command-driven sequencer for the register-file + ALU datapath: queues micro-ops,
// issues one per clock, suppresses x0 writes and skips ops on a zero result.
// Optional feature macro: DPSEQ_PERF_CNT_EN adds saturating issued/skipped counters.
module datapath_sequencer
  import dpseq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ALU_W-1:0]       cmd_alu_op,
  input  logic [REG_W-1:0]       cmd_rs1,
  input  logic [REG_W-1:0]       cmd_rs2,
  input  logic [REG_W-1:0]       cmd_rd,
  input  logic                   cmd_we,
  input  logic                   cmd_skipz,
  input  logic                   hold,
  input  logic                   flush,
  input  logic                   zero_flag,
  output logic [REG_W-1:0]       read_reg_num1,
  output logic [REG_W-1:0]       read_reg_num2,
  output logic [REG_W-1:0]       write_reg,
  output logic [ALU_W-1:0]       alu_control,
  output logic                   regwrite,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
`ifdef DPSEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]       issued_cnt,
  output logic [CNT_W-1:0]       skipped_cnt
`endif
);

  state_e           state_q, state_d;
  cmd_t             push_cmd, head;
  logic [CMD_W-1:0] pop_data;
  logic             full, empty, push, pop;
  logic             zero_last, do_skip, do_issue;

  logic [REG_W-1:0] rs1_q, rs2_q, rd_q;
  logic [ALU_W-1:0] alu_q;
  logic             regwrite_q, active_q, zero_q;

  assign push_cmd = '{alu_op: cmd_alu_op, rs1: cmd_rs1, rs2: cmd_rs2,
                      rd: cmd_rd, we: cmd_we, skipz: cmd_skipz};

  // Ready is held low during reset and on flush so no command slips in.
  assign cmd_ready = reset_n && !full && !flush;
  assign push      = cmd_valid && cmd_ready;
  // Pop is allowed straight out of IDLE so an op issues two edges after its push.
  assign pop       = !hold && !flush && !empty;
  assign head      = cmd_t'(pop_data);
  assign zero_last = active_q ? zero_flag : zero_q;
  assign do_skip   = pop && head.skipz && zero_last;
  assign do_issue  = pop && !do_skip;

  dpseq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (push_cmd),
    .rdata_o (pop_data),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: flush wins, then hold, then queue occupancy.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (!empty) state_d = hold ? ST_HOLD : ST_RUN;
        ST_RUN:  if (hold) state_d = ST_HOLD;
                 else if (empty && !active_q) state_d = ST_IDLE;
        ST_HOLD: if (!hold) state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Issue register: drives the datapath for exactly one cycle per issued op.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      alu_q      <= '0;
      regwrite_q <= 1'b0;
      active_q   <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      if (active_q) zero_q <= zero_flag;
      regwrite_q <= 1'b0;
      active_q   <= 1'b0;
      if (do_issue) begin
        rs1_q      <= head.rs1;
        rs2_q      <= head.rs2;
        rd_q       <= head.rd;
        alu_q      <= head.alu_op;
        regwrite_q <= writes_reg(head);
        active_q   <= 1'b1;
      end
    end
  end

  assign read_reg_num1 = rs1_q;
  assign read_reg_num2 = rs2_q;
  assign write_reg     = rd_q;
  assign alu_control   = alu_q;
  assign regwrite      = regwrite_q;
  assign busy          = !empty || active_q;

`ifdef DPSEQ_PERF_CNT_EN
  logic [CNT_W-1:0] issued_q, skipped_q;

  // Saturating performance counters, cleared by flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      issued_q  <= '0;
      skipped_q <= '0;
    end else if (flush) begin
      issued_q  <= '0;
      skipped_q <= '0;
    end else begin
      if (do_issue && (issued_q != '1))  issued_q  <= issued_q + 1'b1;
      if (do_skip && (skipped_q != '1))  skipped_q <= skipped_q + 1'b1;
    end
  end

  assign issued_cnt  = issued_q;
  assign skipped_cnt = skipped_q;
`endif

endmodule
